// File: rtl/beta_pkg.sv
// Shared definitions for the decode-stage exception sequencer: FSM states,
// cause codes, default handler vectors and the IRQ vector helper.
package beta_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        DRAIN  = 2'd2
    } exc_state_t;

    localparam logic [3:0] EXC_CAUSE_NONE     = 4'd0;
    localparam logic [3:0] EXC_CAUSE_ILLOP    = 4'd1;
    localparam logic [3:0] EXC_CAUSE_IRQ_BASE = 4'd8;

    localparam logic [31:0] DEF_ILLOP_VEC    = 32'h8000_0004;
    localparam logic [31:0] DEF_IRQ_VEC_BASE = 32'h8000_0008;

    // Up to 8 IRQ lines, so the winning index always fits 3 bits.
    localparam int IRQ_IDX_W = 3;

    function automatic logic [31:0] irq_vec(input logic [31:0]          base,
                                            input logic [IRQ_IDX_W-1:0] idx);
        return base + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/irq_pend_arb.sv
// Rising-edge IRQ capture into pending bits, eligibility gating by mask and
// supervisor mode, and a fixed lowest-index-first priority encoder.
module irq_pend_arb
    import beta_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic [NUM_IRQ-1:0]   irq_mask_i,
    input  logic                 sup_i,
    input  logic [NUM_IRQ-1:0]   ack_i,
    output logic                 any_irq_o,
    output logic [IRQ_IDX_W-1:0] irq_idx_o
);

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;

    assign rise = irq_i & ~prev_q;

    // A fresh edge wins over an ack landing in the same cycle.
    assign pend_d = (pend_q & ~ack_i) | rise;

    // prev resets high so a line already asserted across reset needs a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '1;
            pend_q <= '0;
        end else begin
            prev_q <= irq_i;
            pend_q <= pend_d;
        end
    end

    assign elig      = pend_q & irq_mask_i & {NUM_IRQ{~sup_i}};
    assign any_irq_o = |elig;

    always_comb begin
        irq_idx_o = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                irq_idx_o = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Decode-stage exception sequencer: picks illegal-opcode or IRQ traps, injects
// BNE_EXCEPT into decode, redirects fetch to the handler and drains the pipe.
module exc_ctrl
    import beta_pkg::*;
#(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] ILLOP_VEC    = DEF_ILLOP_VEC,
    parameter logic [31:0] IRQ_VEC_BASE = DEF_IRQ_VEC_BASE,
    parameter int          DRAIN_CYC    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               op_ill,
    input  logic               stall,
    input  logic [31:0]        pc_decode,
    output logic               exc_inject,
    output logic               exc_flush,
    output logic               exc_redirect,
    output logic [31:0]        exc_vec,
    output logic [3:0]         exc_cause,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               busy
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    exc_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           cause_q, cause_d;
    logic [31:0]          vec_q, vec_d;
    logic                 is_irq_q, is_irq_d;
    logic [IRQ_IDX_W-1:0] idx_q, idx_d;

    logic                 any_irq;
    logic [IRQ_IDX_W-1:0] irq_idx;
    logic [NUM_IRQ-1:0]   ack_onehot;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^pc_decode[30:0];

    irq_pend_arb #(
        .NUM_IRQ (NUM_IRQ)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_i      (irq),
        .irq_mask_i (irq_mask),
        .sup_i      (pc_decode[31]),
        .ack_i      (irq_ack),
        .any_irq_o  (any_irq),
        .irq_idx_o  (irq_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cause_q  <= EXC_CAUSE_NONE;
            vec_q    <= '0;
            is_irq_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            vec_q    <= vec_d;
            is_irq_q <= is_irq_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        vec_d    = vec_q;
        is_irq_d = is_irq_q;
        idx_d    = idx_q;
        unique case (state_q)
            IDLE: begin
                // Winner is latched here so INJECT outputs come straight from flops.
                if ((op_ill || any_irq) && !stall) begin
                    state_d = INJECT;
                    if (op_ill) begin
                        cause_d  = EXC_CAUSE_ILLOP;
                        vec_d    = ILLOP_VEC;
                        is_irq_d = 1'b0;
                    end else begin
                        cause_d  = EXC_CAUSE_IRQ_BASE | {1'b0, irq_idx};
                        vec_d    = irq_vec(IRQ_VEC_BASE, irq_idx);
                        is_irq_d = 1'b1;
                        idx_d    = irq_idx;
                    end
                end
            end
            INJECT: begin
                state_d = DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYC - 1);
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_onehot   = NUM_IRQ'(1) << idx_q;

    assign exc_inject   = (state_q == INJECT);
    assign exc_redirect = (state_q == INJECT);
    assign exc_flush    = (state_q == DRAIN);
    assign busy         = (state_q != IDLE);
    assign exc_vec      = (state_q == INJECT) ? vec_q : '0;
    assign exc_cause    = cause_q;
    assign irq_ack      = (state_q == INJECT && is_irq_q) ? ack_onehot : '0;

endmodule
